// File: rtl/load_store_unit.sv
// load_store_unit: runs one LB/LH/LW/LBU/LHU/SB/SH/SW access at a time over a valid/ready bus
// and returns aligned, extended load data or a fault. Access codes: 0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW.
module load_store_unit #(
   parameter int TIMEOUT = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  access_type,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [4:0]  rd,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [4:0]  resp_rd,
   output logic [1:0]  resp_fault,
   output logic [31:0] resp_fault_addr,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);
   localparam logic [3:0] AT_LB = 4'd1, AT_LH = 4'd2, AT_LW = 4'd3, AT_LBU = 4'd4;
   localparam logic [3:0] AT_LHU = 4'd5, AT_SB = 4'd6, AT_SH = 4'd7, AT_SW = 4'd8;
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;
   state_t      r_state, w_next;
   logic [3:0]  r_type, r_wstrb, w_wstrb;
   logic [31:0] r_addr, r_cnt, r_rdata, r_wdata, w_wdata, w_shift, w_load;
   logic [4:0]  r_rd;
   logic [1:0]  r_fault, w_off;
   logic        r_we, w_legal, w_store, w_mis, w_accept, w_timeout;
   assign w_off     = addr[1:0];
   assign w_legal   = access_type >= AT_LB && access_type <= AT_SW;
   assign w_store   = access_type == AT_SB || access_type == AT_SH || access_type == AT_SW;
   assign w_mis     = ((access_type == AT_LH || access_type == AT_LHU || access_type == AT_SH) && addr[0])
                   || ((access_type == AT_LW || access_type == AT_SW) && addr[1:0] != 2'b00);
   assign w_accept  = req_valid && req_ready && w_legal;
   assign w_timeout = TIMEOUT != 0 && r_cnt == TO_LAST;
   assign w_wstrb   = access_type == AT_SB ? 4'b0001 << w_off :
                      access_type == AT_SH ? 4'b0011 << w_off :
                      access_type == AT_SW ? 4'b1111 : 4'b0000;
   assign w_wdata   = access_type == AT_SB ? {4{wdata[7:0]}} :
                      access_type == AT_SH ? {2{wdata[15:0]}} :
                      access_type == AT_SW ? wdata : '0;
   // Bring the addressed lane(s) down to bit 0 before extension
   assign w_shift   = mem_rdata >> {r_addr[1:0], 3'b000};
   assign w_load    = r_type == AT_LB  ? {{24{w_shift[7]}}, w_shift[7:0]} :
                      r_type == AT_LBU ? {24'b0, w_shift[7:0]} :
                      r_type == AT_LH  ? {{16{w_shift[15]}}, w_shift[15:0]} :
                      r_type == AT_LHU ? {16'b0, w_shift[15:0]} :
                      r_type == AT_LW  ? mem_rdata : '0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end
   always_comb begin
      w_next = r_state == S_IDLE ? (w_accept ? (w_mis ? S_RESP : S_BUS) : S_IDLE) :
               r_state == S_BUS  ? (mem_ready || w_timeout ? S_RESP : S_BUS) : S_IDLE;
   end
   always_comb begin
      req_ready  = r_state == S_IDLE;
      mem_valid  = r_state == S_BUS;
      resp_valid = r_state == S_RESP;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_type  <= '0;
         r_addr  <= '0;
         r_rd    <= '0;
         r_we    <= 1'b0;
         r_wstrb <= '0;
         r_wdata <= '0;
         r_fault <= '0;
         r_rdata <= '0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_type  <= access_type;
         r_addr  <= addr;
         r_rd    <= rd;
         r_we    <= w_store && !w_mis;
         r_wstrb <= w_mis ? 4'b0000 : w_wstrb;
         r_wdata <= w_wdata;
         r_fault <= w_mis ? 2'b01 : 2'b00;
         r_rdata <= '0;
         r_cnt   <= '0;
      end else if (r_state == S_BUS) begin
         r_cnt <= r_cnt + 32'd1;
         if (mem_ready)      r_rdata <= r_we ? '0 : w_load;
         else if (w_timeout) r_fault <= 2'b10;
      end
   end
   assign mem_addr        = {r_addr[31:2], 2'b00};
   assign mem_we          = r_we;
   assign mem_wstrb       = r_wstrb;
   assign mem_wdata       = r_wdata;
   assign resp_rdata      = r_rdata;
   assign resp_rd         = r_rd;
   assign resp_fault      = r_fault;
   assign resp_fault_addr = r_addr;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench for load_store_unit with a byte-level reference
// model, a bus responder that plans wait states per access, and a response monitor.
module tb_load_store_unit;
   localparam int TO = 8;
   localparam logic [3:0] LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4, LHU = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;
   logic        clk = 1'b0, rst = 1'b1;
   logic        req_valid = 1'b0, req_ready;
   logic [3:0]  access_type = '0;
   logic [31:0] addr = '0, wdata = '0;
   logic [4:0]  rd = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata, resp_fault_addr;
   logic [4:0]  resp_rd;
   logic [1:0]  resp_fault;
   logic        mem_valid, mem_ready = 1'b0, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
   logic [3:0]  mem_wstrb;
   load_store_unit #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .access_type(access_type), .addr(addr), .wdata(wdata), .rd(rd),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
      .resp_fault(resp_fault), .resp_fault_addr(resp_fault_addr),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   typedef struct {
      logic [31:0] rdata;
      logic [4:0]  rd;
      logic [1:0]  fault;
      logic [31:0] faddr;
      int          at;
   } resp_t;
   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      int          wt;
      logic [31:0] rdata;
      int          len;
   } bus_t;
   resp_t exp_q[$];
   bus_t  bus_q[$];
   int    n_vec = 0, n_mis = 0;
   bit    skip_len = 1'b0;
   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction
   function automatic int size_of(logic [3:0] t);
      return (t == LB || t == LBU || t == SB) ? 1 : (t == LH || t == LHU || t == SH) ? 2 : 4;
   endfunction
   function automatic logic [31:0] ref_load(logic [3:0] t, int off, logic [31:0] w);
      logic [7:0]         b[4];
      logic signed [31:0] s;
      for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
      case (t)
         LB:      begin s = $signed(b[off]); return s; end
         LBU:     return {24'b0, b[off]};
         LH:      begin s = $signed({b[off+1], b[off]}); return s; end
         LHU:     return {16'b0, b[off+1], b[off]};
         default: return w;
      endcase
   endfunction
   task automatic issue(logic [3:0] t, logic [31:0] a, logic [31:0] wd, logic [4:0] r, int w, logic [31:0] rw);
      resp_t e;
      bus_t  b;
      int    k, off, sz;
      bit    legal, mis, st, tmo;
      k = 0;
      while (!req_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("req_ready_wait", 32'(req_ready), 32'd1);
      req_valid = 1'b1; access_type = t; addr = a; wdata = wd; rd = r;
      off   = int'(a[1:0]);
      sz    = size_of(t);
      legal = t >= LB && t <= SW;
      mis   = (off % sz) != 0;
      st    = t == SB || t == SH || t == SW;
      tmo   = w >= TO;
      if (legal) begin
         e.rd = r; e.faddr = a;
         if (mis) begin
            e.fault = 2'b01; e.rdata = '0; e.at = cyc + 1;
         end else begin
            e.fault = tmo ? 2'b10 : 2'b00;
            e.rdata = (st || tmo) ? '0 : ref_load(t, off, rw);
            e.at    = cyc + 2 + (w < TO - 1 ? w : TO - 1);
            b.addr  = a & ~32'd3; b.we = st; b.wstrb = '0; b.wdata = '0;
            for (int j = 0; j < 4; j++) begin
               if (st && j >= off && j < off + sz) b.wstrb[j] = 1'b1;
               b.wdata[8*j +: 8] = wd[8*(j % sz) +: 8];
            end
            b.wt = w; b.rdata = rw; b.len = w + 1 < TO ? w + 1 : TO;
            bus_q.push_back(b);
         end
         exp_q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; access_type = 4'($urandom); addr = $urandom; wdata = $urandom; rd = 5'($urandom);
   endtask
   // Bus responder: serves planned wait states and checks request signals every BUS cycle
   initial begin
      int   vcnt;
      bus_t pb;
      vcnt = 0;
      pb = '{addr: 0, we: 0, wstrb: 0, wdata: 0, wt: 1000, rdata: 0, len: 0};
      forever begin
         @(negedge clk);
         mem_ready = 1'b0;
         if (mem_valid) begin
            if (vcnt == 0) begin
               if (bus_q.size() == 0) begin
                  chk("unexpected_mem_valid", 32'(mem_valid), 32'd0);
                  pb = '{addr: mem_addr, we: mem_we, wstrb: mem_wstrb, wdata: mem_wdata, wt: 1000, rdata: 0, len: 0};
               end else pb = bus_q.pop_front();
            end
            chk("mem_addr", mem_addr, pb.addr);
            chk("mem_we", 32'(mem_we), 32'(pb.we));
            chk("mem_wstrb", 32'(mem_wstrb), 32'(pb.wstrb));
            if (pb.we) chk("mem_wdata", mem_wdata, pb.wdata);
            if (vcnt == pb.wt) begin
               mem_ready = 1'b1;
               mem_rdata = pb.rdata;
            end else mem_rdata = $urandom;
            vcnt++;
         end else if (vcnt != 0) begin
            if (!skip_len) chk("mem_valid_len", 32'(vcnt), 32'(pb.len));
            skip_len = 1'b0;
            vcnt = 0;
         end
      end
   end
   // Response monitor
   initial begin
      forever begin
         @(negedge clk);
         if (resp_valid) begin
            if (exp_q.size() == 0) chk("unexpected_resp", 32'(resp_valid), 32'd0);
            else begin
               resp_t e;
               e = exp_q.pop_front();
               chk("resp_rdata", resp_rdata, e.rdata);
               chk("resp_rd", 32'(resp_rd), 32'(e.rd));
               chk("resp_fault", 32'(resp_fault), 32'(e.fault));
               chk("resp_fault_addr", resp_fault_addr, e.faddr);
               chk("resp_cycle", 32'(cyc), 32'(e.at));
               chk("req_ready_in_resp", 32'(req_ready), 32'd0);
            end
         end
      end
   end
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int k, w;
      logic [3:0] t;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_fault", 32'(resp_fault), 32'd0);
      chk("rst_resp_fault_addr", resp_fault_addr, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      issue(LW,  32'h0000_1000, 32'h0,         5'd1, 0,   32'hDEADBEEF);
      issue(LB,  32'h0000_1003, 32'h0,         5'd2, 0,   32'h80FFFFFF);
      issue(LBU, 32'h0000_1003, 32'h0,         5'd3, 1,   32'h80FFFFFF);
      issue(LH,  32'h0000_1002, 32'h0,         5'd4, 2,   32'h80FFFFFF);
      issue(SH,  32'h0000_2002, 32'h1234ABCD,  5'd5, 3,   32'h5555AAAA);
      issue(LW,  32'h0000_1001, 32'h0,         5'd6, 0,   32'h0);
      issue(LW,  32'h0000_1004, 32'h0,         5'd7, 100, 32'h0);
      issue(LHU, 32'h0000_1002, 32'h0,         5'd8, 7,   32'h80FFFFFF);
      issue(4'd0,  32'h0000_3000, 32'h0,       5'd9, 0,   32'h0);
      issue(4'd12, 32'h0000_3000, 32'h0,       5'd9, 0,   32'h0);
      issue(SB,  32'h0000_3001, 32'h000000A5,  5'd10, 0,  32'h0);
      // Reset in the middle of a bus access: the request must vanish without a response
      issue(LW,  32'h0000_4000, 32'h0,         5'd11, 5,  32'h12345678);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
      exp_q.delete();
      bus_q.delete();
      skip_len = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
      for (int i = 0; i < 300; i++) begin
         t = 4'($urandom_range(0, 10));
         w = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 10) : $urandom_range(0, 2);
         issue(t, $urandom, $urandom, 5'($urandom), w, $urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      k = 0;
      while ((exp_q.size() != 0 || bus_q.size() != 0) && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("pending_resp", 32'(exp_q.size()), 32'd0);
      chk("pending_bus", 32'(bus_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
